// File: rtl/aurora_soc_top.sv
// Purpose : aurora SoC top - single-cycle RV32I-subset CPU with internal instruction ROM and data RAM.
// Latency : one instruction retires per rising clk edge; ROM, register and RAM reads are combinational.
// Backpres: none - the core never stalls. Ports: clk (system clock), rst_n (async active-low reset).

// Instruction ROM: no reset, no write port; contents are preloaded hierarchically while reset is held.
// Latency : combinational read. Backpres: none.
// Ports   : idx (word index, wraps modulo DEPTH), instr (read data).
module aurora_irom #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] idx,
  output logic [31:0]   instr
);
  reg [31:0] mem [0:DEPTH-1];

  assign instr = mem[idx];
endmodule

// Register file: 32 x 32-bit, two combinational read ports, one write port.
// Latency : write lands on the rising edge, so a read in the next cycle sees it. Backpres: none.
// Ports   : rs1/rs2 addr+dat read ports, we/rd_addr/rd_dat write port; x0 writes are dropped.
module aurora_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_dat,
  output logic [31:0] rs2_dat,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_dat
);
  logic [31:0] regs [0:31];

  // regs[0] is cleared on reset and never written, so x0 always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_dat;
    end
  end

  assign rs1_dat = regs[rs1_addr];
  assign rs2_dat = regs[rs2_addr];
endmodule

// Data RAM: word-wide, not cleared by reset.
// Latency : combinational read, write on the rising edge. Backpres: none.
// Ports   : idx (word index, wraps modulo DEPTH), we/wdata write port, rdata read port.
module aurora_dram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] idx,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:DEPTH-1];

  // Contents survive reset; only writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

// CPU core: fetch, decode, execute, memory access and writeback all in one cycle.
// Latency : one instruction per clk edge. Backpres: none.
// Ports   : clk, rst_n only; state is observed through the pc register and sub-instance arrays.
module aurora_cpu #(
  parameter int          IROM_DEPTH = 256,
  parameter int          DRAM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n
);
  localparam int IAW = $clog2(IROM_DEPTH);
  localparam int DAW = $clog2(DRAM_DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [31:0] rs1_val, rs2_val;
  logic        rd_we;
  logic [31:0] rd_wdata;
  logic        dram_we;
  logic [31:0] dram_rdata;
  logic [31:0] mem_addr;
  logic [31:0] pc_plus4;

  wire [6:0] opcode = instr[6:0];
  wire [4:0] rd     = instr[11:7];
  wire [2:0] funct3 = instr[14:12];
  wire [4:0] rs1    = instr[19:15];
  wire [4:0] rs2    = instr[24:20];
  wire [6:0] funct7 = instr[31:25];

  wire [31:0] imm_i = {{20{instr[31]}}, instr[31:20]};
  wire [31:0] imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  wire [31:0] imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  wire [31:0] imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  wire [31:0] imm_u = {instr[31:12], 12'b0};

  aurora_irom #(.DEPTH(IROM_DEPTH)) u_d_irom (
    .idx   (pc[IAW+1:2]),
    .instr (instr)
  );

  aurora_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_dat  (rs1_val),
    .rs2_dat  (rs2_val),
    .we       (rd_we),
    .rd_addr  (rd),
    .rd_dat   (rd_wdata)
  );

  // Stores use the S-immediate, everything else (LW) the I-immediate; byte offset bits are ignored.
  assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign pc_plus4 = pc + 32'd4;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:DAW+2], mem_addr[1:0]};

  aurora_dram #(.DEPTH(DRAM_DEPTH)) u_dram (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (mem_addr[DAW+1:2]),
    .we    (dram_we),
    .wdata (rs2_val),
    .rdata (dram_rdata)
  );

  // Decode/execute; any unsupported opcode/funct combination falls through the defaults as a NOP.
  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = '0;
    dram_we  = 1'b0;
    pc_next  = pc_plus4;
    unique case (opcode)
      OP_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OP_OPIMM: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000:  rd_wdata = rs1_val + imm_i;
          3'b010:  rd_wdata = {31'b0, $signed(rs1_val) < $signed(imm_i)};
          3'b100:  rd_wdata = rs1_val ^ imm_i;
          3'b110:  rd_wdata = rs1_val | imm_i;
          3'b111:  rd_wdata = rs1_val & imm_i;
          default: rd_we    = 1'b0;
        endcase
      end
      OP_OP: begin
        rd_we = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: rd_wdata = rs1_val + rs2_val;
            3'b001: rd_wdata = rs1_val << rs2_val[4:0];
            3'b010: rd_wdata = {31'b0, $signed(rs1_val) < $signed(rs2_val)};
            3'b011: rd_wdata = {31'b0, rs1_val < rs2_val};
            3'b100: rd_wdata = rs1_val ^ rs2_val;
            3'b101: rd_wdata = rs1_val >> rs2_val[4:0];
            3'b110: rd_wdata = rs1_val | rs2_val;
            3'b111: rd_wdata = rs1_val & rs2_val;
            default: rd_we   = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          rd_wdata = rs1_val - rs2_val;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          rd_wdata = $unsigned($signed(rs1_val) >>> rs2_val[4:0]);
        end else begin
          rd_we = 1'b0;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rd_we    = 1'b1;
          rd_wdata = dram_rdata;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) dram_we = 1'b1;
      end
      OP_BRANCH: begin
        if ((funct3 == 3'b000 && rs1_val == rs2_val) ||
            (funct3 == 3'b001 && rs1_val != rs2_val)) pc_next = pc + imm_b;
      end
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we    = 1'b1;
          rd_wdata = pc_plus4;
          pc_next  = (rs1_val + imm_i) & ~32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end
endmodule

module aurora_soc_top #(
  parameter int          IROM_DEPTH = 256,
  parameter int          DRAM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n
);
  aurora_cpu #(
    .IROM_DEPTH (IROM_DEPTH),
    .DRAM_DEPTH (DRAM_DEPTH),
    .RESET_PC   (RESET_PC)
  ) u_cpu (
    .clk   (clk),
    .rst_n (rst_n)
  );
endmodule

// File: tb/tb_aurora_soc_top.sv
// Bench for aurora_soc_top: directed programs plus random straight-line programs
// checked against an instruction-level reference model.
module tb_aurora_soc_top;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  aurora_soc_top dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_regs [0:31];
  logic [31:0] m_dram [0:255];
  int          known_q[$];

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic load_rom(input logic [31:0] prog[$]);
    for (int i = 0; i < 256; i++) dut.u_cpu.u_d_irom.mem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.u_cpu.u_d_irom.mem[i] = prog[i];
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut.u_cpu.pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h want %h", dut.u_cpu.pc, 32'h0);
    end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (dut.u_cpu.u_regfile.regs[r] !== 32'h0) begin
        errors++; $display("FAIL reset_x%0d got %h want 0", r, dut.u_cpu.u_regfile.regs[r]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    load_rom('{32'h00500093, 32'h00700113, 32'h002081B3, 32'h00302023, 32'h00002203});
    do_reset(4);
    run(5);
    checks++; if (dut.u_cpu.u_regfile.regs[1] !== 32'd5)  begin errors++; $display("FAIL basic_x1 got %h want 5", dut.u_cpu.u_regfile.regs[1]); end
    checks++; if (dut.u_cpu.u_regfile.regs[2] !== 32'd7)  begin errors++; $display("FAIL basic_x2 got %h want 7", dut.u_cpu.u_regfile.regs[2]); end
    checks++; if (dut.u_cpu.u_regfile.regs[3] !== 32'd12) begin errors++; $display("FAIL basic_x3 got %h want c", dut.u_cpu.u_regfile.regs[3]); end
    checks++; if (dut.u_cpu.u_dram.mem[0] !== 32'd12)     begin errors++; $display("FAIL basic_dram0 got %h want c", dut.u_cpu.u_dram.mem[0]); end
    checks++; if (dut.u_cpu.u_regfile.regs[4] !== 32'd12) begin errors++; $display("FAIL basic_x4 got %h want c", dut.u_cpu.u_regfile.regs[4]); end
    checks++; if (dut.u_cpu.pc !== 32'h14)                begin errors++; $display("FAIL basic_pc got %h want 14", dut.u_cpu.pc); end
  endtask

  task automatic test_sub;
    load_rom('{32'h00500093, 32'h00700113, 32'h002081B3, 32'h00302023, 32'h00002203, 32'h401102B3});
    do_reset(4);
    run(6);
    checks++; if (dut.u_cpu.u_regfile.regs[5] !== 32'd2) begin errors++; $display("FAIL sub_x5 got %h want 2", dut.u_cpu.u_regfile.regs[5]); end
    checks++; if (dut.u_cpu.pc !== 32'h18)               begin errors++; $display("FAIL sub_pc got %h want 18", dut.u_cpu.pc); end
  endtask

  task automatic test_jal;
    load_rom('{32'h008000EF});
    do_reset(2);
    run(1);
    checks++; if (dut.u_cpu.u_regfile.regs[1] !== 32'd4) begin errors++; $display("FAIL jal_x1 got %h want 4", dut.u_cpu.u_regfile.regs[1]); end
    checks++; if (dut.u_cpu.pc !== 32'h8)                begin errors++; $display("FAIL jal_pc got %h want 8", dut.u_cpu.pc); end
  endtask

  task automatic test_beq_loop;
    load_rom('{32'h00000063});
    do_reset(2);
    for (int e = 0; e < 10; e++) begin
      run(1);
      checks++;
      if (dut.u_cpu.pc !== 32'h0) begin errors++; $display("FAIL beq_loop_pc edge %0d got %h want 0", e, dut.u_cpu.pc); end
    end
    for (int r = 1; r < 32; r++) begin
      checks++;
      if (dut.u_cpu.u_regfile.regs[r] !== 32'h0) begin errors++; $display("FAIL beq_loop_x%0d got %h want 0", r, dut.u_cpu.u_regfile.regs[r]); end
    end
  endtask

  // bne not taken, beq taken forward, jalr with odd target
  task automatic test_branch_jalr;
    logic [31:0] p[$];
    p = '{};
    p.push_back(enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011));   // 0:  addi x1,x0,3
    p.push_back(enc_i(12'd3, 5'd0, 3'b000, 5'd2, 7'b0010011));   // 4:  addi x2,x0,3
    p.push_back(enc_b(13'd8, 5'd2, 5'd1, 3'b001));               // 8:  bne  x1,x2,+8
    p.push_back(enc_b(13'd8, 5'd2, 5'd1, 3'b000));               // 12: beq  x1,x2,+8
    p.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'b0010011));   // 16: addi x3,x0,1
    p.push_back(enc_i(12'd29, 5'd0, 3'b000, 5'd4, 7'b1100111));  // 20: jalr x4,29(x0)
    p.push_back(enc_i(12'd2, 5'd0, 3'b000, 5'd3, 7'b0010011));   // 24: addi x3,x0,2
    p.push_back(enc_i(12'd9, 5'd0, 3'b000, 5'd5, 7'b0010011));   // 28: addi x5,x0,9
    p.push_back(enc_b(13'h1FF8, 5'd0, 5'd0, 3'b001));            // 32: bne x0,x0,-8 (not taken)
    load_rom(p);
    do_reset(2);
    run(7);
    checks++; if (dut.u_cpu.u_regfile.regs[3] !== 32'd0)  begin errors++; $display("FAIL br_x3 got %h want 0", dut.u_cpu.u_regfile.regs[3]); end
    checks++; if (dut.u_cpu.u_regfile.regs[4] !== 32'd24) begin errors++; $display("FAIL jalr_x4 got %h want 18", dut.u_cpu.u_regfile.regs[4]); end
    checks++; if (dut.u_cpu.u_regfile.regs[5] !== 32'd9)  begin errors++; $display("FAIL br_x5 got %h want 9", dut.u_cpu.u_regfile.regs[5]); end
    checks++; if (dut.u_cpu.pc !== 32'd36)                begin errors++; $display("FAIL br_pc got %h want 24", dut.u_cpu.pc); end
  endtask

  task automatic test_reset_midrun;
    load_rom('{32'h00500093, 32'h00700113, 32'h002081B3, 32'h00302023, 32'h00002203});
    do_reset(4);
    run(4);
    checks++; if (dut.u_cpu.pc !== 32'h10) begin errors++; $display("FAIL mid_pc_pre got %h want 10", dut.u_cpu.pc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dut.u_cpu.pc !== 32'h0) begin errors++; $display("FAIL mid_pc_async got %h want 0", dut.u_cpu.pc); end
    for (int r = 1; r <= 3; r++) begin
      checks++;
      if (dut.u_cpu.u_regfile.regs[r] !== 32'h0) begin errors++; $display("FAIL mid_x%0d got %h want 0", r, dut.u_cpu.u_regfile.regs[r]); end
    end
    @(posedge clk);
    @(negedge clk);
    checks++; if (dut.u_cpu.u_dram.mem[0] !== 32'd12) begin errors++; $display("FAIL mid_dram0 got %h want c", dut.u_cpu.u_dram.mem[0]); end
    checks++; if (dut.u_cpu.u_regfile.regs[1] !== 32'h0) begin errors++; $display("FAIL mid_hold_x1 got %h want 0", dut.u_cpu.u_regfile.regs[1]); end
    rst_n = 1'b1;
    run(1);
    checks++; if (dut.u_cpu.u_regfile.regs[1] !== 32'd5) begin errors++; $display("FAIL mid_restart_x1 got %h want 5", dut.u_cpu.u_regfile.regs[1]); end
    checks++; if (dut.u_cpu.u_regfile.regs[2] !== 32'd0) begin errors++; $display("FAIL mid_restart_x2 got %h want 0", dut.u_cpu.u_regfile.regs[2]); end
    checks++; if (dut.u_cpu.pc !== 32'h4) begin errors++; $display("FAIL mid_restart_pc got %h want 4", dut.u_cpu.pc); end
  endtask

  task automatic test_x0_nop;
    load_rom('{32'h00500013, 32'hFFFFFFFF});
    do_reset(2);
    run(2);
    checks++; if (dut.u_cpu.u_regfile.regs[0] !== 32'h0) begin errors++; $display("FAIL x0_write got %h want 0", dut.u_cpu.u_regfile.regs[0]); end
    checks++; if (dut.u_cpu.pc !== 32'h8) begin errors++; $display("FAIL nop_pc got %h want 8", dut.u_cpu.pc); end
    for (int r = 1; r < 32; r++) begin
      checks++;
      if (dut.u_cpu.u_regfile.regs[r] !== 32'h0) begin errors++; $display("FAIL nop_x%0d got %h want 0", r, dut.u_cpu.u_regfile.regs[r]); end
    end
  endtask

  // Random straight-line programs; the model executes each instruction as it is generated.
  task automatic test_random(input int n_instr);
    logic [31:0] prog[$];
    logic [31:0] w, a, b, res, simm;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [4:0]  rd, rs1, rs2;
    logic        wr;
    int          kind, idx, j;
    prog = '{};
    known_q = '{};
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    for (int k = 0; k < n_instr; k++) begin
      kind = int'($urandom_range(0, 20));
      rd   = 5'($urandom_range(0, 7));
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      i12  = 12'($urandom_range(0, 4095));
      u20  = 20'($urandom);
      simm = {{20{i12[11]}}, i12};
      a    = m_regs[rs1];
      b    = m_regs[rs2];
      wr   = 1'b1;
      res  = 32'h0;
      w    = 32'h0;
      if (kind >= 18 && known_q.size() == 0) kind = 20;
      case (kind)
        0:  begin w = enc_i(i12, rs1, 3'b000, rd, 7'b0010011); res = a + simm; end
        1:  begin w = enc_i(i12, rs1, 3'b010, rd, 7'b0010011); res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
        2:  begin w = enc_i(i12, rs1, 3'b100, rd, 7'b0010011); res = a ^ simm; end
        3:  begin w = enc_i(i12, rs1, 3'b110, rd, 7'b0010011); res = a | simm; end
        4:  begin w = enc_i(i12, rs1, 3'b111, rd, 7'b0010011); res = a & simm; end
        5:  begin w = {u20, rd, 7'b0110111}; res = {u20, 12'h000}; end
        6:  begin w = enc_r(7'h00, rs2, rs1, 3'b000, rd); res = a + b; end
        7:  begin w = enc_r(7'h20, rs2, rs1, 3'b000, rd); res = a - b; end
        8:  begin w = enc_r(7'h00, rs2, rs1, 3'b111, rd); res = a & b; end
        9:  begin w = enc_r(7'h00, rs2, rs1, 3'b110, rd); res = a | b; end
        10: begin w = enc_r(7'h00, rs2, rs1, 3'b100, rd); res = a ^ b; end
        11: begin w = enc_r(7'h00, rs2, rs1, 3'b010, rd); res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        12: begin w = enc_r(7'h00, rs2, rs1, 3'b011, rd); res = (a < b) ? 32'd1 : 32'd0; end
        13: begin w = enc_r(7'h00, rs2, rs1, 3'b001, rd); res = a << (b % 32); end
        14: begin w = enc_r(7'h00, rs2, rs1, 3'b101, rd); res = a >> (b % 32); end
        15: begin w = enc_r(7'h20, rs2, rs1, 3'b101, rd); res = 32'($signed(a) >>> (b % 32)); end
        16, 17: begin
          w = enc_s(i12, rs2, rs1);
          idx = int'(((a + simm) / 4) % 256);
          m_dram[idx] = b;
          known_q.push_back(idx);
          wr = 1'b0;
        end
        18, 19: begin
          j   = known_q[$urandom_range(0, known_q.size() - 1)];
          i12 = 12'(j * 4 + int'($urandom_range(0, 3)));
          w   = enc_i(i12, 5'd0, 3'b010, rd, 7'b0000011);
          res = m_dram[j];
        end
        default: begin
          // SLLI is outside the supported subset: must behave as a NOP
          w  = enc_i(i12, rs1, 3'b001, rd, 7'b0010011);
          wr = 1'b0;
        end
      endcase
      if (wr && rd != 5'd0) m_regs[rd] = res;
      prog.push_back(w);
    end
    rst_n = 1'b0;
    load_rom(prog);
    do_reset(2);
    run(n_instr);
    checks++;
    if (dut.u_cpu.pc !== 32'(4 * n_instr)) begin
      errors++; $display("FAIL rand_pc got %h want %h", dut.u_cpu.pc, 32'(4 * n_instr));
    end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (dut.u_cpu.u_regfile.regs[r] !== m_regs[r]) begin
        errors++; $display("FAIL rand_x%0d got %h want %h", r, dut.u_cpu.u_regfile.regs[r], m_regs[r]);
      end
    end
    foreach (known_q[q]) begin
      checks++;
      if (dut.u_cpu.u_dram.mem[known_q[q]] !== m_dram[known_q[q]]) begin
        errors++; $display("FAIL rand_dram%0d got %h want %h", known_q[q], dut.u_cpu.u_dram.mem[known_q[q]], m_dram[known_q[q]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sub();
    test_jal();
    test_beq_loop();
    test_branch_jalr();
    test_reset_midrun();
    test_x0_nop();
    for (int p = 0; p < 4; p++) test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
